recip_mul_seq: RTL and testbench
================================

// Module: recip_mul_seq
// PURPOSE
//  Sequential shift-add multiplier: computes n * (1/d), with 1/d supplied as the
//  unsigned fixed-point pair {rq,rf} produced by the reciprocal unit.
//  Completes the divide path (n/d = n * recip(d)) for the perspective-divide
//  stage. Uses valid/ready handshakes on input and output.
//  Each operation processes one multiplier bit per cycle.
// PARAMETERS
//  WIDTH  16  bit width of n, rq, rf, pq and pf
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operand valid
//  in_ready   out  1      block idle and can accept operands
//  n          in   WIDTH  unsigned integer numerator
//  rq         in   WIDTH  reciprocal integer part
//  rf         in   WIDTH  reciprocal fraction part (weight 2^-WIDTH per LSB)
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      downstream accepts result
//  pq         out  WIDTH  product integer part
//  pf         out  WIDTH  product fraction part
//  ovf        out  1      product integer part exceeded WIDTH bits (saturated)
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1, out_valid=0, pq=0, pf=0, ovf=0; clears accumulator.
//  - Reset mid-operation (BUSY or DONE): aborts immediately; the in-flight result is lost.
//  - FSM states:
//    - IDLE -> BUSY on in_valid&&in_ready. Latch n, and latch {rq,rf} as the 2W-bit
//      multiplicand M. Clear the 3W-bit accumulator.
//    - BUSY: each cycle, if the current n LSB is 1 then acc += M << k. Then shift n
//      right and increment k.
//    - BUSY -> DONE after the last iteration. Register the outputs on that edge.
//    - DONE -> IDLE on out_ready. in_ready stays 0 in DONE, so no accept occurs
//      in the same cycle as a result drain.
//  - Latency: handshake in cycle T; out_valid first high in cycle T+WIDTH+1.
//  - in_ready=1 only in IDLE. in_valid is ignored in BUSY and DONE.
//  - Output mapping of the 3W-bit product P:
//    - pf = P[W-1:0]
//    - pq = P[2W-1:W]
//    - ovf = |P[3W-1:2W]
//  - When ovf=1: pq and pf are both set to all ones (saturate).
//  - pq, pf and ovf stay stable while out_valid=1. They keep their values after
//    the drain until the next result.
//  - n=0 and/or M=0 give pq=0, pf=0, ovf=0 with normal latency.
//  - Product is exact. No rounding. The accumulator must not wrap (3W bits).
// CONFIGURATION
//  RECIP_MUL_EARLY_EXIT_EN
//    - Defined: BUSY ends once the remaining shifted n is 0. BUSY then lasts
//      max(1, msb_index(n)+1) cycles, and out_valid is first high at
//      T+1+that count. n=0 takes 1 BUSY cycle.
//    - Undefined: always exactly WIDTH BUSY cycles (fixed latency).
//    - Results are identical either way.
// TESTING (WIDTH=16)
//  1. n=10, rq=0, rf=0x8000 -> pq=5, pf=0x0000, ovf=0;
//     out_valid exactly at T+17 with the macro off.
//  2. n=3, rq=0, rf=0x5555 -> pq=0, pf=0xFFFF, ovf=0.
//  3. n=0xFFFF, rq=0xFFFF, rf=0 -> ovf=1, pq=0xFFFF, pf=0xFFFF.
//  4. n=7, rq=1, rf=0 with out_ready held low for 5 cycles after out_valid
//     -> pq=7, pf=0 held stable and in_ready=0 throughout.
//     Drain -> in_ready=1 the next cycle.
//  5. Assert rst in the 8th BUSY cycle -> next cycle in_ready=1, out_valid=0,
//     pq=pf=0. A fresh op n=2, rf=0x4000 -> pq=0, pf=0x8000.
//  6. Macro on, n=1, rq=0, rf=0x1234 -> pf=0x1234, out_valid at T+2.
//     Macro on, n=0 -> zero result at T+2.

Source files
------------

// File: rtl/recip_mul_seq.sv
// Sequential shift-add multiplier: {pq,pf} = n * {rq,rf}, one multiplier bit per cycle, saturating on overflow.
// Latency WIDTH+1 cycles from accept to out_valid (RECIP_MUL_EARLY_EXIT_EN: stops once remaining n is zero).
// Backpressure: in_ready only while idle; the result is held with out_valid until out_ready.
module recip_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] rq,
  input  logic [WIDTH-1:0] rf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pq,
  output logic [WIDTH-1:0] pf,
  output logic             ovf
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   n_sh;
  logic [3*WIDTH-1:0] m_sh;
  logic [3*WIDTH-1:0] acc;
  logic [3*WIDTH-1:0] acc_nxt;
  logic [KW-1:0]      k;
  logic               last;
  logic               hi_nz;

  assign acc_nxt = n_sh[0] ? (acc + m_sh) : acc;
  assign hi_nz   = |acc_nxt[3*WIDTH-1:2*WIDTH];

`ifdef RECIP_MUL_EARLY_EXIT_EN
  // Nothing left to add once the remaining multiplier bits are all zero.
  assign last = (n_sh[WIDTH-1:1] == '0) || (k == KW'(WIDTH-1));
`else
  assign last = (k == KW'(WIDTH-1));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_sh <= '0;
      m_sh <= '0;
      acc  <= '0;
      k    <= '0;
      pq   <= '0;
      pf   <= '0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            n_sh <= n;
            m_sh <= {{WIDTH{1'b0}}, rq, rf};
            acc  <= '0;
            k    <= '0;
          end
        end
        BUSY: begin
          acc  <= acc_nxt;
          n_sh <= n_sh >> 1;
          m_sh <= m_sh << 1;
          k    <= k + 1'b1;
          if (last) begin
            ovf <= hi_nz;
            pq  <= hi_nz ? {WIDTH{1'b1}} : acc_nxt[2*WIDTH-1:WIDTH];
            pf  <= hi_nz ? {WIDTH{1'b1}} : acc_nxt[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_recip_mul_seq.sv
// Directed bench for recip_mul_seq (WIDTH=16); expected latency follows RECIP_MUL_EARLY_EXIT_EN.
module tb_recip_mul_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] n, rq, rf;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] pq, pf;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  recip_mul_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .n(n), .rq(rq), .rf(rf),
    .out_valid(out_valid), .out_ready(out_ready),
    .pq(pq), .pf(pf), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycles from the accept cycle T to the first out_valid cycle.
  function automatic int lat_of(input logic [W-1:0] tn);
`ifdef RECIP_MUL_EARLY_EXIT_EN
    int msb = -1;
    for (int i = 0; i < W; i++) if (tn[i]) msb = i;
    return 1 + ((msb + 1) > 1 ? (msb + 1) : 1);
`else
    return W + 1;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input string tag, input logic [W-1:0] tn, trq, trf);
    n = tn; rq = trq; rf = trf;
    in_valid = 1'b1;
    check({tag, ".in_ready_idle"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    n = '0; rq = '0; rf = '0;
  endtask

  task automatic wait_valid(output int c);
    c = 1;
    while (!out_valid && c < 40) begin
      step();
      c++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] tn, trq, trf,
                        input logic [W-1:0] epq, epf, input logic eovf);
    int c;
    out_ready = 1'b1;
    start_op(tag, tn, trq, trf);
    check({tag, ".busy_in_ready"}, in_ready, 1'b0);
    wait_valid(c);
    check({tag, ".latency"}, 64'(c), 64'(lat_of(tn)));
    check({tag, ".pq"}, pq, epq);
    check({tag, ".pf"}, pf, epf);
    check({tag, ".ovf"}, ovf, eovf);
    step();
    check({tag, ".drained_out_valid"}, out_valid, 1'b0);
    check({tag, ".drained_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    int c;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    n = '0; rq = '0; rf = '0;
    repeat (2) step();
    check("reset.in_ready", in_ready, 1'b1);
    check("reset.out_valid", out_valid, 1'b0);
    check("reset.pq", pq, '0);
    check("reset.pf", pf, '0);
    check("reset.ovf", ovf, 1'b0);
    rst = 1'b0;
    step();

    run_op("t1_half", 16'd10, 16'h0000, 16'h8000, 16'd5, 16'h0000, 1'b0);
    run_op("t2_third", 16'd3, 16'h0000, 16'h5555, 16'd0, 16'hFFFF, 1'b0);
    run_op("t3_sat", 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b1);

    // Result held under backpressure.
    out_ready = 1'b0;
    start_op("t4_hold", 16'd7, 16'h0001, 16'h0000);
    wait_valid(c);
    check("t4_hold.latency", 64'(c), 64'(lat_of(16'd7)));
    for (int i = 0; i < 5; i++) begin
      check("t4_hold.pq", pq, 16'd7);
      check("t4_hold.pf", pf, 16'd0);
      check("t4_hold.in_ready", in_ready, 1'b0);
      check("t4_hold.out_valid", out_valid, 1'b1);
      step();
    end
    out_ready = 1'b1;
    check("t4_hold.pre_drain_valid", out_valid, 1'b1);
    step();
    check("t4_hold.drain_in_ready", in_ready, 1'b1);
    check("t4_hold.drain_out_valid", out_valid, 1'b0);
    check("t4_hold.kept_pq", pq, 16'd7);

    // Abort in the 8th BUSY cycle.
    start_op("t5_abort", 16'hFFFF, 16'h0000, 16'h0001);
    repeat (7) step();
    check("t5_abort.busy_in_ready", in_ready, 1'b0);
    check("t5_abort.busy_out_valid", out_valid, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_abort.in_ready", in_ready, 1'b1);
    check("t5_abort.out_valid", out_valid, 1'b0);
    check("t5_abort.pq", pq, '0);
    check("t5_abort.pf", pf, '0);
    run_op("t5_fresh", 16'd2, 16'h0000, 16'h4000, 16'd0, 16'h8000, 1'b0);

    run_op("t6_one", 16'd1, 16'h0000, 16'h1234, 16'd0, 16'h1234, 1'b0);
    run_op("t6_zero", 16'd0, 16'h1234, 16'h5678, 16'd0, 16'd0, 1'b0);
    run_op("t6_mzero", 16'd9, 16'h0000, 16'h0000, 16'd0, 16'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
